// File: rtl/dispatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dispatch_pkg
//  Description : Shared constants and types for the dispatch demultiplexer
//                and its 2-entry destination queues.
//  Revision    : 1.0 - initial release
// ============================================================================
package dispatch_pkg;

    // Depth of each destination queue and width of the per-destination counters
    localparam int QDEPTH = 2;
    localparam int CNT_W  = 16;

    // Read/write pointer into a 2-entry queue
    typedef logic [0:0] ptr_t;

    // Occupancy of a queue: 0, 1 or 2 entries
    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_FULL  = 2'd2;

    // Transfer counter type
    typedef logic [CNT_W-1:0] cnt_t;

endpackage : dispatch_pkg
`default_nettype wire

// File: rtl/fifo2.sv
`default_nettype none
// ============================================================================
//  Module      : fifo2
//  Description : Two-entry synchronous FIFO. Output is the registered head
//                entry; there is no path from din to dout in the same cycle.
//                Push while full and pop while empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo2
    import dispatch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [QDEPTH];
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    occ_t             occ_q,    occ_d;

    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (occ_q == OCC_EMPTY);
    assign full      = (occ_q == OCC_FULL);
    assign dout      = mem_q[rd_ptr_q];

    // Guard against overflow/underflow regardless of what the caller requests
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop  & ~empty;

    // Next-state for pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
        case ({w_do_push, w_do_pop})
            2'b10:   occ_d = occ_q + occ_t'(1);
            2'b01:   occ_d = occ_q - occ_t'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Control state; reset empties the queue immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= OCC_EMPTY;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Payload storage; contents are meaningless while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule : fifo2
`default_nettype wire

// File: rtl/dispatch_demux.sv
`default_nettype none
// ============================================================================
//  Module      : dispatch_demux
//  Description : Routes a valid/ready input stream to one of two outputs by
//                in_sel, buffering each destination in its own 2-entry FIFO
//                and counting accepted payloads per destination.
//  Revision    : 1.0 - initial release
// ============================================================================
module dispatch_demux
    import dispatch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic w_full0, w_full1;
    logic w_empty0, w_empty1;
    logic w_push0, w_push1;
    logic w_pop0, w_pop1;

    cnt_t cnt0_q, cnt0_d;
    cnt_t cnt1_q, cnt1_d;

    // Ready depends only on the selected queue having room, so a full
    // queue never stalls traffic aimed at the other one
    assign in_ready   = in_sel ? ~w_full1 : ~w_full0;

    assign w_push0    = in_valid & in_ready & ~in_sel;
    assign w_push1    = in_valid & in_ready &  in_sel;

    assign out0_valid = ~w_empty0;
    assign out1_valid = ~w_empty1;
    assign w_pop0     = out0_valid & out0_ready;
    assign w_pop1     = out1_valid & out1_ready;

    fifo2 #(
        .WIDTH (WIDTH)
    ) u_q0 (
        .clk   (clk),
        .reset (reset),
        .push  (w_push0),
        .pop   (w_pop0),
        .din   (in_data),
        .dout  (out0_data),
        .empty (w_empty0),
        .full  (w_full0)
    );

    fifo2 #(
        .WIDTH (WIDTH)
    ) u_q1 (
        .clk   (clk),
        .reset (reset),
        .push  (w_push1),
        .pop   (w_pop1),
        .din   (in_data),
        .dout  (out1_data),
        .empty (w_empty1),
        .full  (w_full1)
    );

    // Counter next-state: one per accepted payload, wrapping naturally
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (w_push0) begin
            cnt0_d = cnt0_q + cnt_t'(1);
        end
        if (w_push1) begin
            cnt1_d = cnt1_q + cnt_t'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;

endmodule : dispatch_demux
`default_nettype wire

// File: tb/tb_dispatch_demux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dispatch_demux
//  Description : Self-checking bench for dispatch_demux: directed scenarios
//                plus randomized traffic against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dispatch_demux;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [15:0]      cnt0;
    logic [15:0]      cnt1;

    int total;
    int bad;

    // Reference model: one queue per destination plus counters
    logic [WIDTH-1:0] q0m [$];
    logic [WIDTH-1:0] q1m [$];
    logic [15:0]      mcnt0;
    logic [15:0]      mcnt1;

    dispatch_demux #(
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge, applying the transfer rules to the model using
    // the inputs presented before the edge; returns 1 time unit after the edge
    task automatic tick();
        bit acc;
        bit p0;
        bit p1;
        @(posedge clk);
        if (!reset) begin
            acc = in_valid && ((in_sel ? q1m.size() : q0m.size()) < 2);
            p0  = out0_ready && (q0m.size() > 0);
            p1  = out1_ready && (q1m.size() > 0);
            if (p0) void'(q0m.pop_front());
            if (p1) void'(q1m.pop_front());
            if (acc) begin
                if (in_sel) begin
                    q1m.push_back(in_data);
                    mcnt1 = mcnt1 + 16'd1;
                end else begin
                    q0m.push_back(in_data);
                    mcnt0 = mcnt0 + 16'd1;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = '0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        q0m.delete();
        q1m.delete();
        mcnt0 = '0;
        mcnt1 = '0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        total += 4;
        if (out0_valid !== 1'b0) begin bad++; $display("FAIL rst_out0_valid actual=%b expected=0", out0_valid); end
        if (out1_valid !== 1'b0) begin bad++; $display("FAIL rst_out1_valid actual=%b expected=0", out1_valid); end
        if (cnt0 !== 16'd0) begin bad++; $display("FAIL rst_cnt0 actual=%h expected=0000", cnt0); end
        if (cnt1 !== 16'd0) begin bad++; $display("FAIL rst_cnt1 actual=%h expected=0000", cnt1); end
        in_sel = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready_sel0 actual=%b expected=1", in_ready); end
        in_sel = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready_sel1 actual=%b expected=1", in_ready); end
    endtask

    task automatic test_routing();
        do_reset();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 32'hA;
        #1;
        total++;
        if (out0_valid !== 1'b0) begin bad++; $display("FAIL route_no_bypass actual=%b expected=0", out0_valid); end
        tick();
        total += 2;
        if (out0_valid !== 1'b1) begin bad++; $display("FAIL route_out0_valid actual=%b expected=1", out0_valid); end
        if (out0_data !== 32'hA) begin bad++; $display("FAIL route_out0_data actual=%h expected=0000000a", out0_data); end
        in_sel  = 1'b1;
        in_data = 32'hB;
        tick();
        in_valid = 1'b0;
        total += 5;
        if (out1_valid !== 1'b1) begin bad++; $display("FAIL route_out1_valid actual=%b expected=1", out1_valid); end
        if (out1_data !== 32'hB) begin bad++; $display("FAIL route_out1_data actual=%h expected=0000000b", out1_data); end
        if (out0_valid !== 1'b0) begin bad++; $display("FAIL route_out0_popped actual=%b expected=0", out0_valid); end
        if (cnt0 !== 16'd1) begin bad++; $display("FAIL route_cnt0 actual=%h expected=0001", cnt0); end
        if (cnt1 !== 16'd1) begin bad++; $display("FAIL route_cnt1 actual=%h expected=0001", cnt1); end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] got [$];
        bit acc;
        bit first;
        do_reset();
        out0_ready = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 32'd1;
        tick();
        in_data    = 32'd2;
        tick();
        in_data    = 32'd3;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready actual=%b expected=0", in_ready); end
        tick();
        total++;
        if (cnt0 !== 16'd2) begin bad++; $display("FAIL bp_stall_cnt0 actual=%h expected=0002", cnt0); end
        out0_ready = 1'b1;
        #1;
        first = 1'b1;
        for (int i = 0; i < 8; i++) begin
            acc = in_valid && in_ready;
            if (first) begin
                total++;
                if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_pop_in_ready actual=%b expected=0", in_ready); end
                first = 1'b0;
            end
            if (out0_valid) got.push_back(out0_data);
            tick();
            if (acc) in_valid = 1'b0;
        end
        total++;
        if (got.size() != 3) begin
            bad++; $display("FAIL bp_pop_count actual=%0d expected=3", got.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (got[k] !== WIDTH'(k + 1)) begin bad++; $display("FAIL bp_order[%0d] actual=%h expected=%h", k, got[k], k + 1); end
            end
        end
        total++;
        if (cnt0 !== 16'd3) begin bad++; $display("FAIL bp_cnt0 actual=%h expected=0003", cnt0); end
    endtask

    task automatic test_independence();
        do_reset();
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 32'h11;
        tick();
        in_data    = 32'h22;
        tick();
        in_sel     = 1'b1;
        in_data    = 32'h55;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL indep_in_ready actual=%b expected=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total += 4;
        if (out1_valid !== 1'b1) begin bad++; $display("FAIL indep_out1_valid actual=%b expected=1", out1_valid); end
        if (out1_data !== 32'h55) begin bad++; $display("FAIL indep_out1_data actual=%h expected=00000055", out1_data); end
        if (cnt1 !== 16'd1) begin bad++; $display("FAIL indep_cnt1 actual=%h expected=0001", cnt1); end
        if (out0_data !== 32'h11) begin bad++; $display("FAIL indep_out0_head actual=%h expected=00000011", out0_data); end
    endtask

    task automatic test_full_pop();
        do_reset();
        out0_ready = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 32'h11;
        tick();
        in_data    = 32'h22;
        tick();
        out0_ready = 1'b1;
        in_data    = 32'h33;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL fp_in_ready_full actual=%b expected=0", in_ready); end
        tick();
        total += 3;
        if (cnt0 !== 16'd2) begin bad++; $display("FAIL fp_no_push_cnt0 actual=%h expected=0002", cnt0); end
        if (out0_data !== 32'h22) begin bad++; $display("FAIL fp_head actual=%h expected=00000022", out0_data); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL fp_in_ready_after actual=%b expected=1", in_ready); end
        out0_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        total += 2;
        if (cnt0 !== 16'd3) begin bad++; $display("FAIL fp_push_cnt0 actual=%h expected=0003", cnt0); end
        if (in_ready !== 1'b0) begin bad++; $display("FAIL fp_refull_in_ready actual=%b expected=0", in_ready); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        out0_ready = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 32'h1;
        tick();
        in_data    = 32'h2;
        tick();
        in_valid   = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total += 3;
        if (out0_valid !== 1'b0) begin bad++; $display("FAIL mid_out0_valid actual=%b expected=0", out0_valid); end
        if (cnt0 !== 16'd0) begin bad++; $display("FAIL mid_cnt0 actual=%h expected=0000", cnt0); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready actual=%b expected=1", in_ready); end
        in_valid   = 1'b1;
        out0_ready = 1'b1;
        @(posedge clk);
        #1;
        total += 2;
        if (cnt0 !== 16'd0) begin bad++; $display("FAIL mid_held_cnt0 actual=%h expected=0000", cnt0); end
        if (out0_valid !== 1'b0) begin bad++; $display("FAIL mid_held_valid actual=%b expected=0", out0_valid); end
        #1;
        reset = 1'b0;
        q0m.delete();
        q1m.delete();
        mcnt0 = '0;
        mcnt1 = '0;
        out0_ready = 1'b0;
        in_data    = 32'h77;
        tick();
        in_valid = 1'b0;
        total += 2;
        if (cnt0 !== 16'd1) begin bad++; $display("FAIL mid_first_cnt0 actual=%h expected=0001", cnt0); end
        if (out0_data !== 32'h77) begin bad++; $display("FAIL mid_first_data actual=%h expected=00000077", out0_data); end
    endtask

    task automatic test_random();
        bit exp_rdy;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            in_sel     = 1'($urandom_range(0, 1));
            in_data    = $urandom;
            out0_ready = 1'($urandom_range(0, 1));
            out1_ready = 1'($urandom_range(0, 1));
            #1;
            exp_rdy = ((in_sel ? q1m.size() : q0m.size()) < 2);
            total++;
            if (in_ready !== exp_rdy) begin bad++; $display("FAIL rnd_in_ready cyc=%0d actual=%b expected=%b", i, in_ready, exp_rdy); end
            tick();
            total += 4;
            if (out0_valid !== (q0m.size() > 0)) begin bad++; $display("FAIL rnd_out0_valid cyc=%0d actual=%b expected=%b", i, out0_valid, q0m.size() > 0); end
            if (out1_valid !== (q1m.size() > 0)) begin bad++; $display("FAIL rnd_out1_valid cyc=%0d actual=%b expected=%b", i, out1_valid, q1m.size() > 0); end
            if (cnt0 !== mcnt0) begin bad++; $display("FAIL rnd_cnt0 cyc=%0d actual=%h expected=%h", i, cnt0, mcnt0); end
            if (cnt1 !== mcnt1) begin bad++; $display("FAIL rnd_cnt1 cyc=%0d actual=%h expected=%h", i, cnt1, mcnt1); end
            if (q0m.size() > 0) begin
                total++;
                if (out0_data !== q0m[0]) begin bad++; $display("FAIL rnd_out0_data cyc=%0d actual=%h expected=%h", i, out0_data, q0m[0]); end
            end
            if (q1m.size() > 0) begin
                total++;
                if (out1_data !== q1m[0]) begin bad++; $display("FAIL rnd_out1_data cyc=%0d actual=%h expected=%h", i, out1_data, q1m[0]); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        out1_ready = 1'b1;
        in_valid   = 1'b1;
        in_sel     = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            in_data = i;
            tick();
            if (i == 65534) begin
                total++;
                if (cnt1 !== 16'hFFFF) begin bad++; $display("FAIL wrap_cnt1_max actual=%h expected=ffff", cnt1); end
            end
        end
        in_valid = 1'b0;
        total += 2;
        if (cnt1 !== 16'h0000) begin bad++; $display("FAIL wrap_cnt1 actual=%h expected=0000", cnt1); end
        if (cnt0 !== 16'h0000) begin bad++; $display("FAIL wrap_cnt0 actual=%h expected=0000", cnt0); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = '0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        mcnt0      = '0;
        mcnt1      = '0;
        test_reset();
        test_routing();
        test_backpressure();
        test_independence();
        test_full_pop();
        test_reset_midstream();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dispatch_demux
`default_nettype wire

// File: doc/dispatch_demux.md
DISPATCH_DEMUX -- requirements
Module: dispatch_demux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data payload width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-004 The block SHALL have port in_data, input, WIDTH bits, the upstream payload.
REQ-005 The block SHALL have port in_sel, input, 1 bit, the destination select: 0 routes to out0, 1 routes to out1.
REQ-006 The block SHALL have port in_valid, input, 1 bit, asserted when upstream offers a payload.
REQ-007 The block SHALL have port in_ready, output, 1 bit, asserted when the payload will be accepted.
REQ-008 The block SHALL have ports out0_data, output, WIDTH bits, and out1_data, output, WIDTH bits, the head payload of each destination queue.
REQ-009 The block SHALL have ports out0_valid, output, 1 bit, and out1_valid, output, 1 bit, asserted when the corresponding queue is non-empty.
REQ-010 The block SHALL have ports out0_ready, input, 1 bit, and out1_ready, input, 1 bit, the downstream accept signals.
REQ-011 The block SHALL have ports cnt0, output, 16 bits, and cnt1, output, 16 bits, counting payloads accepted toward each destination.

Function
REQ-012 The block SHALL contain one 2-entry FIFO per destination, queue q0 and queue q1.
REQ-013 The block SHALL drive in_ready = ~full(q[in_sel]) combinationally; in_ready SHALL NOT depend on in_valid or on outN_ready.
REQ-014 An input transfer SHALL occur on a clk edge where in_valid & in_ready; in_data SHALL be written to the tail of q[in_sel].
REQ-015 An output transfer on destination N SHALL occur on a clk edge where outN_valid & outN_ready, and SHALL pop the head of qN.
REQ-016 outN_valid SHALL equal "qN not empty", and outN_data SHALL equal the head entry of qN; outN_data SHALL be don't-care while outN_valid = 0.
REQ-017 Latency SHALL be exactly 1 cycle: a payload accepted at edge t SHALL be visible on outN at the earliest after edge t; there is no combinational bypass from in_data to out.
REQ-018 Each queue SHALL preserve FIFO order; ordering between q0 and q1 is not preserved.
REQ-019 On a simultaneous push and pop on the same non-full, non-empty queue, both SHALL occur and the occupancy SHALL be unchanged.
REQ-020 When a queue is full, no push SHALL occur even if that queue pops in the same cycle; in_ready is 0 for that select.
REQ-021 A pop request on an empty queue is impossible because outN_valid = 0; occupancy SHALL never underflow below 0 or exceed 2.
REQ-022 A full q0 SHALL NOT block traffic selected to q1, and a full q1 SHALL NOT block traffic selected to q0.
REQ-023 cntN SHALL increment by 1 on each input transfer to destination N, and SHALL wrap from 0xFFFF to 0x0000.
REQ-024 A change of in_sel while in_valid = 1 and in_ready = 0 SHALL be permitted; only the select value sampled at the transfer edge matters.

Reset
REQ-025 While reset = 1, asynchronously and regardless of clk, both queues SHALL be emptied: out0_valid = 0, out1_valid = 0, cnt0 = 0, cnt1 = 0.
REQ-026 While reset = 1, in_ready SHALL be 1 for either select.
REQ-027 Reset asserted mid-operation SHALL discard all queued payloads, and no output transfer SHALL be reported during reset.
REQ-028 The first transfer after reset SHALL be the first clk edge with reset = 0.

Structure
REQ-029 Package dispatch_pkg SHALL hold the constants QDEPTH = 2 and CNT_W = 16, and the typedef for the queue pointer/occupancy.
REQ-030 Sub-module fifo2 (parameter WIDTH; ports push, pop, din, dout, empty, full, clk, reset) SHALL be instantiated twice; routing and counters reside in the top level.

Verification
REQ-031 Reset mid-stream: q0 holding 2 entries, assert reset -> out0_valid = 0 immediately, cnt0 = 0, in_ready = 1.
REQ-032 Routing: push 0xA (sel = 0) then 0xB (sel = 1) with both readies = 1 -> out0_data = 0xA and out1_data = 0xB, each one cycle after its accept; cnt0 = cnt1 = 1.
REQ-033 Full/backpressure: out0_ready = 0, push 1, 2, 3 with sel = 0 -> third stalls with in_ready = 0; raise out0_ready -> pops 1, 2, then 3 in order.
REQ-034 Independence: q0 full; push 0x55 with sel = 1 -> in_ready = 1, accepted, out1_data = 0x55.
REQ-035 Full with pop: q0 full and out0_ready = 1, present sel = 0 -> no push that cycle; occupancy drops to 1; next cycle push accepted.
REQ-036 Counter wrap: force 65536 transfers to out1 -> cnt1 returns to 0x0000 and cnt0 remains 0.
